// File: rtl/neuron_grid_datapath.sv
// -----------------------------------------------------------------------------
// neuron_grid_datapath
//
// Per-core neuron datapath driven by the neuron grid controller. Holds the
// neuron and axon counters, the tick spike register, the per-neuron membrane
// potential store and the integrate / leak / fire arithmetic. Fired neurons
// are collected into a vector that is published to the router once per tick.
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_scheduler_set/_clr      latch / clear the tick spike register; clear
//                             also publishes the fire vector
//   i_axon_spikes_in          axon spikes for this tick
//   i_initial_/i_inc_neuron_num, i_initial_/i_inc_axon_num
//                             counter controls (initial has priority)
//   i_new_neuron              load accumulator from the potential store
//   i_process_spike           integrate the current axon into the accumulator
//   i_update_potential        apply leak/threshold and write back
//   o_neuron_num, o_axon_num  addresses to parameter / synapse memories
//   i_syn_bit, i_axon_type    combinational synapse memory read data
//   i_param_*                 combinational neuron parameter read data
//   o_done_neuron, o_done_axon  counters at their last value
//   o_spike_in                current neuron fires (combinational)
//   o_out_spikes, o_out_valid published spike vector and one-cycle strobe
// -----------------------------------------------------------------------------
module neuron_grid_datapath #(
    parameter int NUM_NEURONS = 256,
    parameter int NUM_AXONS   = 256,
    parameter int WEIGHT_W    = 9,
    parameter int POT_W       = 16,
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int AW = (NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_scheduler_set,
    input  logic                       i_scheduler_clr,
    input  logic [NUM_AXONS-1:0]       i_axon_spikes_in,
    input  logic                       i_initial_neuron_num,
    input  logic                       i_inc_neuron_num,
    input  logic                       i_initial_axon_num,
    input  logic                       i_inc_axon_num,
    input  logic                       i_new_neuron,
    input  logic                       i_process_spike,
    input  logic                       i_update_potential,
    output logic [NW-1:0]              o_neuron_num,
    output logic [AW-1:0]              o_axon_num,
    input  logic                       i_syn_bit,
    input  logic [1:0]                 i_axon_type,
    input  logic [4*WEIGHT_W-1:0]      i_param_weights,
    input  logic signed [POT_W-1:0]    i_param_leak,
    input  logic signed [POT_W-1:0]    i_param_threshold,
    input  logic signed [POT_W-1:0]    i_param_reset,
    output logic                       o_done_neuron,
    output logic                       o_done_axon,
    output logic                       o_spike_in,
    output logic [NUM_NEURONS-1:0]     o_out_spikes,
    output logic                       o_out_valid
);

    localparam logic [NW-1:0] NEURON_MAX = NW'(NUM_NEURONS - 1);
    localparam logic [AW-1:0] AXON_MAX   = AW'(NUM_AXONS - 1);
    localparam logic signed [POT_W-1:0] POT_MAX = {1'b0, {(POT_W-1){1'b1}}};
    localparam logic signed [POT_W-1:0] POT_MIN = {1'b1, {(POT_W-1){1'b0}}};

    // Add two potentials, clamping to the signed range instead of wrapping.
    function automatic logic signed [POT_W-1:0] sat_add(
        input logic signed [POT_W-1:0] a,
        input logic signed [POT_W-1:0] b
    );
        logic [POT_W:0] s;
        s = {a[POT_W-1], a} + {b[POT_W-1], b};
        if (s[POT_W] != s[POT_W-1])
            return s[POT_W] ? POT_MIN : POT_MAX;
        return s[POT_W-1:0];
    endfunction

    function automatic logic signed [POT_W-1:0] sext_weight(
        input logic [WEIGHT_W-1:0] w
    );
        return {{(POT_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
    endfunction

    logic [NW-1:0]             r_neuron_num;
    logic [AW-1:0]             r_axon_num;
    logic [NUM_AXONS-1:0]      r_spikes;
    logic signed [POT_W-1:0]   r_acc;
    logic signed [POT_W-1:0]   r_pot_mem [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]    r_fire_vec;
    logic [NUM_NEURONS-1:0]    r_out_spikes;
    logic                      r_out_valid;

    logic [NW-1:0]             w_neuron_inc;
    logic [AW-1:0]             w_axon_inc;
    logic [NW-1:0]             w_target;
    logic [WEIGHT_W-1:0]       w_weight;
    logic signed [POT_W-1:0]   w_acc_sum;
    logic signed [POT_W-1:0]   w_v_next;
    logic                      w_fire;
    logic                      w_process;

    assign w_neuron_inc = (r_neuron_num == NEURON_MAX) ? '0 : r_neuron_num + 1'b1;
    assign w_axon_inc   = (r_axon_num == AXON_MAX) ? '0 : r_axon_num + 1'b1;

    // The controller may advance the neuron counter in the same cycle as the
    // load, so read the store at the address the counter is about to hold.
    assign w_target = i_initial_neuron_num ? '0 :
                      i_inc_neuron_num     ? w_neuron_inc : r_neuron_num;

    assign w_weight  = i_param_weights[i_axon_type*WEIGHT_W +: WEIGHT_W];
    assign w_acc_sum = sat_add(r_acc, sext_weight(w_weight));
    assign w_v_next  = sat_add(r_acc, i_param_leak);
    assign w_fire    = (w_v_next >= i_param_threshold);

    // While the axon counter is being re-initialised its current value is a
    // leftover from the previous neuron, so no integration is allowed.
    assign w_process = i_process_spike && !i_initial_axon_num &&
                       r_spikes[r_axon_num] && i_syn_bit;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_neuron_num <= '0;
            r_axon_num   <= '0;
        end else begin
            if (i_initial_neuron_num)
                r_neuron_num <= '0;
            else if (i_inc_neuron_num)
                r_neuron_num <= w_neuron_inc;

            if (i_initial_axon_num)
                r_axon_num <= '0;
            else if (i_inc_axon_num)
                r_axon_num <= w_axon_inc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_spikes <= '0;
        else if (i_scheduler_set)
            r_spikes <= i_axon_spikes_in;
        else if (i_scheduler_clr)
            r_spikes <= '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_acc <= '0;
        else if (i_new_neuron)
            r_acc <= r_pot_mem[w_target];
        else if (w_process)
            r_acc <= w_acc_sum;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_NEURONS; i++)
                r_pot_mem[i] <= '0;
        end else if (i_update_potential) begin
            r_pot_mem[r_neuron_num] <= w_fire ? i_param_reset : w_v_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_fire_vec <= '0;
        else if (i_initial_neuron_num)
            r_fire_vec <= '0;
        else if (i_update_potential && w_fire)
            r_fire_vec[r_neuron_num] <= 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_spikes <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            r_out_valid <= i_scheduler_clr;
            if (i_scheduler_clr)
                r_out_spikes <= r_fire_vec;
        end
    end

    assign o_neuron_num  = r_neuron_num;
    assign o_axon_num    = r_axon_num;
    assign o_done_neuron = (r_neuron_num == NEURON_MAX);
    assign o_done_axon   = (r_axon_num == AXON_MAX);
    assign o_spike_in    = w_fire;
    assign o_out_spikes  = r_out_spikes;
    assign o_out_valid   = r_out_valid;

endmodule

// File: tb/tb_neuron_grid_datapath.sv
// -----------------------------------------------------------------------------
// tb_neuron_grid_datapath
//
// Directed bench for neuron_grid_datapath with a 4-neuron, 4-axon core.
// Parameter and synapse memories are modelled as arrays read combinationally
// on the DUT addresses. Published spike vectors are checked by a scoreboard.
// -----------------------------------------------------------------------------
module tb_neuron_grid_datapath;

    localparam int NN = 4;
    localparam int NA = 4;
    localparam int WW = 9;
    localparam int PW = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   scheduler_set, scheduler_clr;
    logic [NA-1:0]          axon_spikes_in;
    logic                   initial_neuron_num, inc_neuron_num;
    logic                   initial_axon_num, inc_axon_num;
    logic                   new_neuron, process_spike, update_potential;
    logic [1:0]             neuron_num;
    logic [1:0]             axon_num;
    logic                   syn_bit;
    logic [1:0]             axon_type;
    logic [4*WW-1:0]        param_weights;
    logic signed [PW-1:0]   param_leak, param_threshold, param_reset;
    logic                   done_neuron, done_axon, spike_in;
    logic [NN-1:0]          out_spikes;
    logic                   out_valid;

    // Memory model contents
    logic signed [WW-1:0]   wt    [NN][4];
    logic signed [PW-1:0]   leak  [NN];
    logic signed [PW-1:0]   thr   [NN];
    logic signed [PW-1:0]   rstv  [NN];
    logic [1:0]             atype [NA];
    logic                   syn   [NA][NN];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [NN-1:0] spk;
        int            due;
    } exp_t;
    exp_t q[$];

    neuron_grid_datapath #(
        .NUM_NEURONS(NN), .NUM_AXONS(NA), .WEIGHT_W(WW), .POT_W(PW)
    ) dut (
        .i_clk(clk), .i_reset(reset),
        .i_scheduler_set(scheduler_set), .i_scheduler_clr(scheduler_clr),
        .i_axon_spikes_in(axon_spikes_in),
        .i_initial_neuron_num(initial_neuron_num), .i_inc_neuron_num(inc_neuron_num),
        .i_initial_axon_num(initial_axon_num), .i_inc_axon_num(inc_axon_num),
        .i_new_neuron(new_neuron), .i_process_spike(process_spike),
        .i_update_potential(update_potential),
        .o_neuron_num(neuron_num), .o_axon_num(axon_num),
        .i_syn_bit(syn_bit), .i_axon_type(axon_type),
        .i_param_weights(param_weights), .i_param_leak(param_leak),
        .i_param_threshold(param_threshold), .i_param_reset(param_reset),
        .o_done_neuron(done_neuron), .o_done_axon(done_axon),
        .o_spike_in(spike_in), .o_out_spikes(out_spikes), .o_out_valid(out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        param_weights = '0;
        for (int k = 0; k < 4; k++)
            param_weights[k*WW +: WW] = wt[neuron_num][k];
        param_leak      = leak[neuron_num];
        param_threshold = thr[neuron_num];
        param_reset     = rstv[neuron_num];
        axon_type       = atype[axon_num];
        syn_bit         = syn[axon_num][neuron_num];
    end

    // Scoreboard monitor: every out_valid must match the oldest expected
    // publish, both in content and in the cycle it appears.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_checks++;
            if (q.size() == 0) begin
                n_errors++;
                $display("FAIL out_valid_unexpected: got out_valid=1 spikes=%b, required no publish", out_spikes);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (out_spikes !== e.spk || cyc != e.due) begin
                    n_errors++;
                    $display("FAIL publish: got spikes=%b at cycle %0d, required spikes=%b at cycle %0d",
                             out_spikes, cyc, e.spk, e.due);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        scheduler_set = 0; scheduler_clr = 0;
        initial_neuron_num = 0; inc_neuron_num = 0;
        initial_axon_num = 0; inc_axon_num = 0;
        new_neuron = 0; process_spike = 0; update_potential = 0;
    endtask

    task automatic set_spikes(input logic [NA-1:0] v);
        scheduler_set = 1; axon_spikes_in = v;
        tick(); clear_ctl();
    endtask

    task automatic goto_neuron(input int n);
        initial_neuron_num = 1;
        tick(); clear_ctl();
        for (int i = 0; i < n; i++) begin
            inc_neuron_num = 1;
            tick(); clear_ctl();
        end
    endtask

    task automatic inc_neuron();
        inc_neuron_num = 1;
        tick(); clear_ctl();
    endtask

    task automatic load();
        new_neuron = 1; initial_axon_num = 1;
        tick(); clear_ctl();
    endtask

    task automatic integrate(input int cnt);
        for (int k = 0; k < cnt; k++) begin
            check("done_axon_during_spike_in", done_axon, (k == NA-1));
            process_spike = 1; inc_axon_num = 1;
            tick(); clear_ctl();
        end
    endtask

    task automatic update();
        update_potential = 1;
        tick(); clear_ctl();
    endtask

    task automatic publish(input logic [NN-1:0] exp_spk);
        exp_t e;
        e.spk = exp_spk;
        e.due = cyc + 1;
        q.push_back(e);
        scheduler_clr = 1;
        tick(); clear_ctl();
    endtask

    // Threshold probe: spike_in = (acc + leak >= t) pins down acc exactly.
    task automatic probe(input int n, input logic signed [PW-1:0] t, input logic e, input string nm);
        thr[n] = t;
        #1;
        check(nm, spike_in, e);
    endtask

    initial begin
        clear_ctl();
        axon_spikes_in = '0;
        for (int n = 0; n < NN; n++) begin
            for (int k = 0; k < 4; k++) wt[n][k] = '0;
            leak[n] = 0; thr[n] = 1000; rstv[n] = 0;
        end
        for (int a = 0; a < NA; a++) begin
            atype[a] = 2'(a);
            for (int n = 0; n < NN; n++) syn[a][n] = 1'b1;
        end

        reset = 1;
        tick(); tick();
        reset = 0;

        // Reset state
        check("rst_neuron_num", neuron_num, 0);
        check("rst_axon_num", axon_num, 0);
        check("rst_done_neuron", done_neuron, 0);
        check("rst_done_axon", done_axon, 0);
        check("rst_out_spikes", out_spikes, 0);
        check("rst_out_valid", out_valid, 0);

        // Integration: 5 - 3 + 100 = 102 on neuron 0
        wt[0][0] = 5; wt[0][1] = -3; wt[0][2] = 7; wt[0][3] = 100;
        set_spikes(4'b1011);
        goto_neuron(0);
        load();
        integrate(NA);
        probe(0, 102, 1, "integ_acc_ge_102");
        probe(0, 103, 0, "integ_acc_lt_103");
        probe(0, 1000, 0, "integ_spike_in");
        update();
        publish(4'b0000);
        set_spikes(4'b0000);
        load();
        probe(0, 102, 1, "integ_pot_ge_102");
        probe(0, 103, 0, "integ_pot_lt_103");

        // Fire/reset on neuron 1: potential 95, +10, leak -2 -> 103 fires
        wt[1][0] = 95;
        set_spikes(4'b0001);
        goto_neuron(1);
        load();
        integrate(NA);
        update();
        wt[1][0] = 10; leak[1] = -2; rstv[1] = 7;
        load();
        integrate(NA);
        probe(1, 103, 1, "fire_vnext_ge_103");
        probe(1, 104, 0, "fire_vnext_lt_104");
        probe(1, 100, 1, "fire_spike_in");
        update();
        publish(4'b0010);
        leak[1] = 0;
        load();
        probe(1, 7, 1, "fire_pot_ge_7");
        probe(1, 8, 0, "fire_pot_lt_8");

        // Positive saturation on neuron 2: 32760 + 100 -> 32767
        goto_neuron(2);
        thr[2] = -1000; rstv[2] = 32760;
        set_spikes(4'b0000);
        load();
        update();
        thr[2] = 1000; wt[2][0] = 100;
        set_spikes(4'b0001);
        load();
        integrate(NA);
        probe(2, 32767, 1, "sat_pos_acc_max");
        thr[2] = 1000;

        // Negative saturation on neuron 3: -32765 - 50 -> -32768
        inc_neuron();
        check("done_neuron_at_max", done_neuron, 1);
        check("neuron_num_at_max", neuron_num, 3);
        thr[3] = -32768; rstv[3] = -32765;
        set_spikes(4'b0000);
        load();
        update();
        leak[3] = -50;
        load();
        probe(3, -32768, 1, "sat_neg_vnext_ge_min");
        probe(3, -32767, 0, "sat_neg_vnext_lt_min1");
        thr[3] = 1000; leak[3] = 0;
        inc_neuron();
        check("neuron_wrap", neuron_num, 0);
        check("done_neuron_after_wrap", done_neuron, 0);
        publish(4'b1100);

        // Stale-address guard on neuron 0 (potential 102)
        set_spikes(4'b1000);
        load();
        for (int i = 0; i < 3; i++) begin
            inc_axon_num = 1;
            tick(); clear_ctl();
        end
        check("axon_num_at_3", axon_num, 3);
        check("done_axon_at_max", done_axon, 1);
        process_spike = 1; initial_axon_num = 1;
        tick(); clear_ctl();
        probe(0, 102, 1, "stale_acc_ge_102");
        probe(0, 103, 0, "stale_acc_lt_103");
        check("axon_num_after_initial", axon_num, 0);
        for (int i = 0; i < 3; i++) begin
            inc_axon_num = 1;
            tick(); clear_ctl();
        end
        process_spike = 1;
        tick(); clear_ctl();
        probe(0, 202, 1, "fresh_acc_ge_202");
        probe(0, 203, 0, "fresh_acc_lt_203");

        // Counter priorities and look-ahead load
        inc_neuron();
        inc_neuron();
        initial_neuron_num = 1; inc_neuron_num = 1;
        tick(); clear_ctl();
        check("initial_beats_inc", neuron_num, 0);
        new_neuron = 1; inc_neuron_num = 1;
        tick(); clear_ctl();
        check("lookahead_neuron_num", neuron_num, 1);
        probe(1, 7, 1, "lookahead_acc_ge_7");
        probe(1, 8, 0, "lookahead_acc_lt_8");
        new_neuron = 1; initial_neuron_num = 1;
        tick(); clear_ctl();
        probe(0, 102, 1, "initload_acc_ge_102");
        probe(0, 103, 0, "initload_acc_lt_103");

        // Reset mid-SPIKE_IN with acc = 37 on neuron 1
        inc_neuron();
        wt[1][0] = 10; wt[1][1] = 10; wt[1][2] = 10; wt[1][3] = 0;
        set_spikes(4'b0111);
        load();
        integrate(3);
        probe(1, 37, 1, "pre_reset_acc_ge_37");
        probe(1, 38, 0, "pre_reset_acc_lt_38");
        for (int n = 0; n < NN; n++) begin
            thr[n] = 1000; leak[n] = 0;
        end
        reset = 1; process_spike = 1; inc_axon_num = 1;
        tick();
        check("in_reset_out_valid_1", out_valid, 0);
        tick();
        check("in_reset_out_valid_2", out_valid, 0);
        reset = 0; clear_ctl();
        check("post_reset_neuron_num", neuron_num, 0);
        check("post_reset_axon_num", axon_num, 0);
        check("post_reset_done_neuron", done_neuron, 0);
        check("post_reset_done_axon", done_axon, 0);
        check("post_reset_spike_in", spike_in, 0);
        check("post_reset_out_spikes", out_spikes, 0);
        check("post_reset_out_valid", out_valid, 0);
        for (int n = 0; n < NN; n++) begin
            load();
            probe(n, 0, 1, "post_reset_pot_ge_0");
            probe(n, 1, 0, "post_reset_pot_lt_1");
            if (n == 0) begin
                integrate(NA);
                probe(0, 1, 0, "post_reset_spikes_cleared");
            end
            thr[n] = 1000;
            inc_neuron();
        end
        publish(4'b0000);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        check("scoreboard_drained", q.size(), 0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
